instr_mem_loader: RTL and testbench

Write-side companion to the core's instruction memory. It receives a framed byte stream over a valid/ready interface and assembles little-endian 32-bit instruction words. Each word is written into the instruction RAM at consecutive word addresses, and the CPU is held in reset until a complete, checksum-verified image has been written. It sits between the host byte link (UART receiver) and the write port of the instruction RAM that replaces the fixed ROM.

---
 rtl/instr_mem_loader.sv | 127 ++++++++++++
 tb/tb_instr_mem_loader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the instruction RAM: assembles little-endian words from a framed,
// XOR-checksummed stream and holds the core in reset until a verified image is written.
module instr_mem_loader #(
   parameter int         DEPTH_LOG2 = 5,
   parameter logic [7:0] MAGIC      = 8'hA5
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [7:0]  RX_DATA,
   input  logic        RX_VALID,
   output logic        RX_READY,
   output logic        WE,
   output logic [31:0] WADDR,
   output logic [31:0] WDATA,
   output logic        CPU_RST,
   output logic        DONE,
   output logic        ERR
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COUNT,
      S_DATA,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   state_t                  r_state;
   state_t                  w_nextState;
   logic [DEPTH_LOG2-1:0]   r_wordIdx;
   logic [1:0]              r_byteIdx;
   logic [7:0]              r_xor;
   logic [7:0]              r_count;
   logic [23:0]             r_asm;
   logic                    r_we;
   logic [31:0]             r_waddr;
   logic [31:0]             r_wdata;

   logic                    w_accept;
   logic                    w_countZero;
   logic                    w_countOk;
   logic                    w_lastWord;

   assign RX_READY    = ~RST;
   assign w_accept    = RX_VALID & RX_READY;
   assign w_countZero = (RX_DATA == 8'd0);
   assign w_countOk   = ({24'd0, RX_DATA} <= 32'(DEPTH));
   // The final word keeps its index so N = DEPTH never wraps the word counter.
   assign w_lastWord  = (({{(32-DEPTH_LOG2){1'b0}}, r_wordIdx} + 32'd1) == {24'd0, r_count});

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      if (w_accept) begin
         case (r_state)
            S_IDLE:  if (RX_DATA == MAGIC) w_nextState = S_COUNT;
            S_COUNT: begin
               if (w_countZero)    w_nextState = S_CHECK;
               else if (w_countOk) w_nextState = S_DATA;
               else                w_nextState = S_ERROR;
            end
            S_DATA:  if (r_byteIdx == 2'd3 && w_lastWord) w_nextState = S_CHECK;
            S_CHECK: w_nextState = (RX_DATA == r_xor) ? S_DONE : S_ERROR;
            S_DONE,
            S_ERROR: if (RX_DATA == MAGIC) w_nextState = S_COUNT;
            default: w_nextState = S_IDLE;
         endcase
      end
   end

   // Datapath: byte assembly, running checksum and the registered RAM write port.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_wordIdx <= '0;
         r_byteIdx <= 2'd0;
         r_xor     <= 8'd0;
         r_count   <= 8'd0;
         r_asm     <= 24'd0;
         r_we      <= 1'b0;
         r_waddr   <= 32'd0;
         r_wdata   <= 32'd0;
      end else begin
         r_we <= 1'b0;
         if (w_accept) begin
            case (r_state)
               S_COUNT: begin
                  r_count   <= RX_DATA;
                  r_wordIdx <= '0;
                  r_byteIdx <= 2'd0;
                  r_xor     <= 8'd0;
               end
               S_DATA: begin
                  r_xor     <= r_xor ^ RX_DATA;
                  r_byteIdx <= r_byteIdx + 2'd1;
                  case (r_byteIdx)
                     2'd0: r_asm[7:0]   <= RX_DATA;
                     2'd1: r_asm[15:8]  <= RX_DATA;
                     2'd2: r_asm[23:16] <= RX_DATA;
                     default: begin
                        r_we    <= 1'b1;
                        r_waddr <= {{(30-DEPTH_LOG2){1'b0}}, r_wordIdx, 2'b00};
                        r_wdata <= {RX_DATA, r_asm};
                        if (!w_lastWord) r_wordIdx <= r_wordIdx + 1'b1;
                     end
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

   assign WE      = r_we;
   assign WADDR   = r_waddr;
   assign WDATA   = r_wdata;
   assign DONE    = (r_state == S_DONE);
   assign ERR     = (r_state == S_ERROR);
   assign CPU_RST = (r_state != S_DONE);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected RAM writes are queued by the stimulus,
// and a negedge monitor pops and compares them whenever WE is seen.
module tb_instr_mem_loader;

   logic        CLK;
   logic        RST;
   logic [7:0]  RX_DATA;
   logic        RX_VALID;
   logic        RX_READY;
   logic        WE;
   logic [31:0] WADDR;
   logic [31:0] WDATA;
   logic        CPU_RST;
   logic        DONE;
   logic        ERR;

   int nCompared   = 0;
   int nMismatched = 0;

   logic [63:0] expQ[$];
   logic [7:0]  txQ[$];
   bit          prevWe = 1'b0;

   instr_mem_loader #(.DEPTH_LOG2(5), .MAGIC(8'hA5)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .RX_DATA  (RX_DATA),
      .RX_VALID (RX_VALID),
      .RX_READY (RX_READY),
      .WE       (WE),
      .WADDR    (WADDR),
      .WDATA    (WDATA),
      .CPU_RST  (CPU_RST),
      .DONE     (DONE),
      .ERR      (ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Monitor: every WE pulse must match the oldest queued write and last exactly one cycle.
   always @(negedge CLK) begin
      if (!RST && WE) begin
         checkOutput("we_single_cycle", {31'd0, prevWe}, 32'd0);
         if (expQ.size() == 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write", WADDR, WDATA);
         end else begin
            logic [63:0] exp;
            exp = expQ.pop_front();
            checkOutput("waddr", WADDR, exp[63:32]);
            checkOutput("wdata", WDATA, exp[31:0]);
         end
      end
      prevWe = (!RST) && WE;
   end

   task automatic expectWrite(input logic [31:0] addr, input logic [31:0] data);
      expQ.push_back({addr, data});
   endtask

   task automatic applyStimulus(input bit toggle);
      while (txQ.size() != 0) begin
         RX_DATA  = txQ.pop_front();
         RX_VALID = 1'b1;
         @(posedge CLK);
         #1;
         if (toggle) begin
            RX_VALID = 1'b0;
            @(posedge CLK);
            #1;
         end
      end
      RX_VALID = 1'b0;
   endtask

   task automatic drainWrites(input string name);
      for (int i = 0; i < 10 && expQ.size() != 0; i++) @(posedge CLK);
      #1;
      checkOutput(name, expQ.size(), 32'd0);
   endtask

   task automatic loadFrameA(input logic [7:0] chk);
      txQ = '{8'hA5, 8'h02, 8'h93, 8'h02, 8'h10, 8'h00, 8'h13, 8'h03, 8'h00, 8'h00};
      txQ.push_back(chk);
      expectWrite(32'h0000_0000, 32'h0010_0293);
      expectWrite(32'h0000_0004, 32'h0000_0313);
   endtask

   task automatic checkStatus(input string name, input logic done, input logic err, input logic cpuRst);
      checkOutput({name, "_done"}, {31'd0, DONE}, {31'd0, done});
      checkOutput({name, "_err"}, {31'd0, ERR}, {31'd0, err});
      checkOutput({name, "_cpu_rst"}, {31'd0, CPU_RST}, {31'd0, cpuRst});
   endtask

   task automatic checkResetValues(input string name);
      checkOutput({name, "_we"}, {31'd0, WE}, 32'd0);
      checkOutput({name, "_waddr"}, WADDR, 32'd0);
      checkOutput({name, "_wdata"}, WDATA, 32'd0);
      checkOutput({name, "_rx_ready"}, {31'd0, RX_READY}, 32'd0);
      checkStatus(name, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      logic [7:0]  bigBytes[128];
      logic [7:0]  bigChk;

      RST      = 1'b1;
      RX_DATA  = 8'h00;
      RX_VALID = 1'b0;
      #1;
      checkResetValues("reset");
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      checkOutput("rx_ready_after_reset", {31'd0, RX_READY}, 32'd1);
      @(posedge CLK);
      #1;

      // Junk bytes before an empty frame
      txQ = '{8'h00, 8'hFF, 8'h13};
      applyStimulus(1'b0);
      checkStatus("junk", 1'b0, 1'b0, 1'b1);
      txQ = '{8'hA5, 8'h00, 8'h00};
      applyStimulus(1'b0);
      checkStatus("empty_frame", 1'b1, 1'b0, 1'b0);
      drainWrites("empty_frame_no_writes");

      // Restart from DONE: magic alone puts the core back in reset
      txQ = '{8'hA5};
      applyStimulus(1'b0);
      checkStatus("restart_magic", 1'b0, 1'b0, 1'b1);
      txQ = '{8'h02, 8'h93, 8'h02, 8'h10, 8'h00, 8'h13, 8'h03, 8'h00, 8'h00, 8'h91};
      expectWrite(32'h0000_0000, 32'h0010_0293);
      expectWrite(32'h0000_0004, 32'h0000_0313);
      applyStimulus(1'b0);
      checkStatus("frame_a", 1'b1, 1'b0, 1'b0);
      drainWrites("frame_a_writes");
      checkOutput("frame_a_waddr_held", WADDR, 32'h0000_0004);
      checkOutput("frame_a_wdata_held", WDATA, 32'h0000_0313);

      // Bad checksum: words still written, then error
      loadFrameA(8'h90);
      applyStimulus(1'b0);
      checkStatus("bad_chk", 1'b0, 1'b1, 1'b1);
      drainWrites("bad_chk_writes");

      // Valid frame with RX_VALID toggling recovers from error
      loadFrameA(8'h91);
      applyStimulus(1'b1);
      checkStatus("toggled", 1'b1, 1'b0, 1'b0);
      drainWrites("toggled_writes");

      // Word count one beyond memory depth
      txQ = '{8'hA5, 8'h21};
      applyStimulus(1'b0);
      checkStatus("too_long", 1'b0, 1'b1, 1'b1);
      repeat (3) @(posedge CLK);
      drainWrites("too_long_no_writes");

      // Full-depth image
      bigChk = 8'h00;
      txQ = '{8'hA5, 8'h20};
      for (int i = 0; i < 128; i++) begin
         bigBytes[i] = 8'((i * 37 + 11) & 8'hFF);
         bigChk ^= bigBytes[i];
         txQ.push_back(bigBytes[i]);
      end
      txQ.push_back(bigChk);
      for (int w = 0; w < 32; w++)
         expectWrite(32'(w * 4), {bigBytes[4*w+3], bigBytes[4*w+2], bigBytes[4*w+1], bigBytes[4*w]});
      applyStimulus(1'b0);
      checkStatus("full_depth", 1'b1, 1'b0, 1'b0);
      drainWrites("full_depth_writes");
      checkOutput("full_depth_last_waddr", WADDR, 32'h0000_007C);

      // Reset after the sixth byte of a frame
      txQ = '{8'hA5, 8'h02, 8'h93, 8'h02, 8'h10, 8'h00};
      expectWrite(32'h0000_0000, 32'h0010_0293);
      applyStimulus(1'b0);
      @(negedge CLK);
      #2;
      RST = 1'b1;
      #1;
      checkResetValues("mid_frame_reset");
      checkOutput("mid_frame_reset_queue", expQ.size(), 32'd0);
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK);
      #1;
      loadFrameA(8'h91);
      applyStimulus(1'b0);
      checkStatus("after_reset", 1'b1, 1'b0, 1'b0);
      drainWrites("after_reset_writes");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
